wishbone_interconnect_n: RTL and testbench

- Parametrised successor to the fixed two-slave wishbone interconnect; routes one wishbone master to NUM_SLAVES slaves.
- Slave index is decoded from a configurable address field. Slave 0 is always device_rom_table; wb_ddr and user slaves occupy 1..N-1.
- Adds behaviour the fixed version lacks: registered request/response pipeline, a per-transaction bus timeout with error response, out-of-range decode error, and a masked interrupt aggregator with a last-error capture register.

---
 rtl/wishbone_interconnect_n_pkg.sv | 24 ++
 rtl/wishbone_interconnect_n_timeout.sv | 36 +++
 rtl/wishbone_interconnect_n.sv | 202 ++++++++++++++++++++
 tb/tb_wishbone_interconnect_n.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_interconnect_n_pkg.sv
// ---------------------------------------------------------------------------
// wishbone_interconnect_n_pkg
// Shared definitions for the N-slave wishbone interconnect:
//   - FSM state encodings (IDLE/BUSY/RESP/RELEASE)
//   - default slave-ack timeout and slave-select field width
//   - idx_width(): width of a slave index for a given slave count
// No ports (package).
// ---------------------------------------------------------------------------
package wishbone_interconnect_n_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int DEFAULT_TIMEOUT   = 255;
    localparam int DEFAULT_SEL_WIDTH = 8;

    // A single slave still needs a one-bit index so that vectors stay legal.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wishbone_interconnect_n_timeout.sv
// ---------------------------------------------------------------------------
// wb_timeout_counter
// Counts cycles spent waiting for a slave acknowledge.
//   clk, rst : clock, asynchronous active-high reset
//   load     : clear the count (start of a new slave access)
//   en       : count this cycle (waiting for ack)
//   expire   : high in the LIMIT-th enabled cycle after a load
// ---------------------------------------------------------------------------
module wb_timeout_counter #(
    parameter int LIMIT = 255,
    parameter int WIDTH = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + WIDTH'(1);
        end
    end

    // Count holds the number of already-completed waiting cycles, so the
    // current cycle is the LIMIT-th when it equals LIMIT-1.
    assign expire = en && (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/wishbone_interconnect_n.sv
// ---------------------------------------------------------------------------
// wishbone_interconnect_n
// Routes one wishbone master to NUM_SLAVES slaves through a registered
// request/response pipeline. Slave index comes from m_adr_i[SEL_LSB+:SEL_WIDTH];
// slave 0 is device_rom_table, slaves 1..N-1 are wb_ddr and user devices.
//
// Handshake: a request is accepted in IDLE when m_cyc_i & m_stb_i. Exactly one
// m_ack_o pulse answers it (m_err_o qualifies that pulse), after which the
// master must drop m_stb_i before a new request is taken. Dropping m_cyc_i
// while the slave is being waited on aborts with no ack.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m_we_i/m_cyc_i/m_stb_i   master write enable, cycle, strobe
//   m_sel_i/m_adr_i/m_dat_i  master byte select, address, write data
//   m_dat_o/m_ack_o/m_err_o  registered read data, ack pulse, error qualifier
//   m_int_o                  registered OR of masked slave interrupts
//   int_mask_i               per-slave interrupt enable
//   err_adr_o                address of the most recent errored transfer
//   s_we_o/s_cyc_o/s_stb_o   per-slave strobes (one-hot or zero)
//   s_sel_o/s_adr_o/s_dat_o  flattened byte selects, addresses, write data
//   s_dat_i/s_ack_i/s_int_i  flattened read data, acks, interrupts
//   fsm_state                current FSM state (debug observation)
// ---------------------------------------------------------------------------
module wishbone_interconnect_n
    import wishbone_interconnect_n_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_LSB        = 24,
    parameter int SEL_WIDTH      = DEFAULT_SEL_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               m_we_i,
    input  logic                               m_cyc_i,
    input  logic                               m_stb_i,
    input  logic [DATA_WIDTH/8-1:0]            m_sel_i,
    input  logic [ADDR_WIDTH-1:0]              m_adr_i,
    input  logic [DATA_WIDTH-1:0]              m_dat_i,
    output logic [DATA_WIDTH-1:0]              m_dat_o,
    output logic                               m_ack_o,
    output logic                               m_err_o,
    output logic                               m_int_o,
    input  logic [NUM_SLAVES-1:0]              int_mask_i,
    output logic [ADDR_WIDTH-1:0]              err_adr_o,
    output logic [NUM_SLAVES-1:0]              s_we_o,
    output logic [NUM_SLAVES-1:0]              s_cyc_o,
    output logic [NUM_SLAVES-1:0]              s_stb_o,
    output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] s_sel_o,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   s_adr_o,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_dat_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_dat_i,
    input  logic [NUM_SLAVES-1:0]              s_ack_i,
    input  logic [NUM_SLAVES-1:0]              s_int_i,
    output logic [1:0]                         fsm_state
);

    localparam int BSEL_W = DATA_WIDTH / 8;
    localparam int IDX_W  = idx_width(NUM_SLAVES);
    localparam int SW1    = SEL_WIDTH + 1;
    localparam logic [SW1-1:0] NUM_SLAVES_EXT = SW1'(NUM_SLAVES);

    function automatic logic [ADDR_WIDTH-1:0] field_mask();
        logic [ADDR_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (i >= SEL_LSB && i < SEL_LSB + SEL_WIDTH) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Bits of the address that form the slave-select field.
    localparam logic [ADDR_WIDTH-1:0] SEL_MASK = field_mask();

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] lat_adr;
    logic [DATA_WIDTH-1:0] lat_dat;
    logic [BSEL_W-1:0]     lat_sel;
    logic                  lat_we;
    logic [IDX_W-1:0]      cur_idx;
    logic [NUM_SLAVES-1:0] slv_stb;
    logic [NUM_SLAVES-1:0] slv_we;

    logic [SEL_WIDTH-1:0]  req_sel;
    logic                  req_valid;
    logic                  req_in_range;
    logic                  sel_ack;
    logic [DATA_WIDTH-1:0] sel_rdat;
    logic                  tmo_load;
    logic                  tmo_en;
    logic                  tmo_expire;

    assign req_sel      = m_adr_i[SEL_LSB +: SEL_WIDTH];
    assign req_valid    = m_cyc_i & m_stb_i;
    assign req_in_range = {1'b0, req_sel} < NUM_SLAVES_EXT;
    assign sel_ack      = s_ack_i[cur_idx];
    assign sel_rdat     = s_dat_i[int'(cur_idx) * DATA_WIDTH +: DATA_WIDTH];

    // The counter restarts whenever a request is accepted and runs only
    // while the selected slave is being waited on.
    assign tmo_load = (state == ST_IDLE) && req_valid;
    assign tmo_en   = (state == ST_BUSY);

    wb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH ($clog2(TIMEOUT_CYCLES + 1))
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (tmo_load),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lat_adr   <= '0;
            lat_dat   <= '0;
            lat_sel   <= '0;
            lat_we    <= 1'b0;
            cur_idx   <= '0;
            slv_stb   <= '0;
            slv_we    <= '0;
            m_dat_o   <= '0;
            m_ack_o   <= 1'b0;
            m_err_o   <= 1'b0;
            m_int_o   <= 1'b0;
            err_adr_o <= '0;
        end else begin
            // Ack/err are single-cycle pulses; only the transition into RESP sets them.
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_int_o <= |(s_int_i & int_mask_i);

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_adr <= m_adr_i;
                        lat_dat <= m_dat_i;
                        lat_sel <= m_sel_i;
                        lat_we  <= m_we_i;
                        if (!req_in_range) begin
                            state     <= ST_RESP;
                            m_ack_o   <= 1'b1;
                            m_err_o   <= 1'b1;
                            m_dat_o   <= '0;
                            err_adr_o <= m_adr_i;
                        end else begin
                            state   <= ST_BUSY;
                            cur_idx <= req_sel[IDX_W-1:0];
                            slv_stb <= NUM_SLAVES'(1) << req_sel[IDX_W-1:0];
                            slv_we  <= m_we_i ? (NUM_SLAVES'(1) << req_sel[IDX_W-1:0]) : '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!m_cyc_i) begin
                        state   <= ST_IDLE;
                        slv_stb <= '0;
                        slv_we  <= '0;
                    end else if (sel_ack) begin
                        // Ack is checked before expiry so a same-cycle ack still succeeds.
                        state   <= ST_RESP;
                        slv_stb <= '0;
                        slv_we  <= '0;
                        m_ack_o <= 1'b1;
                        m_dat_o <= lat_we ? '0 : sel_rdat;
                    end else if (tmo_expire) begin
                        state     <= ST_RESP;
                        slv_stb   <= '0;
                        slv_we    <= '0;
                        m_ack_o   <= 1'b1;
                        m_err_o   <= 1'b1;
                        m_dat_o   <= '0;
                        err_adr_o <= lat_adr;
                    end
                end
                ST_RESP: begin
                    state <= ST_RELEASE;
                end
                default: begin
                    // RELEASE: a strobe still held from the answered request must
                    // not start a second transfer.
                    if (!m_stb_i) state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_cyc_o   = slv_stb;
    assign s_stb_o   = slv_stb;
    assign s_we_o    = slv_we;
    assign s_adr_o   = {NUM_SLAVES{lat_adr & ~SEL_MASK}};
    assign s_dat_o   = {NUM_SLAVES{lat_dat}};
    assign s_sel_o   = {NUM_SLAVES{lat_sel}};
    assign fsm_state = state;

endmodule

// File: tb/tb_wishbone_interconnect_n.sv
module tb_wishbone_interconnect_n;
    import wishbone_interconnect_n_pkg::*;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 8;

    logic            clk;
    logic            rst;
    logic            m_we_i, m_cyc_i, m_stb_i;
    logic [3:0]      m_sel_i;
    logic [AW-1:0]   m_adr_i;
    logic [DW-1:0]   m_dat_i;
    logic [DW-1:0]   m_dat_o;
    logic            m_ack_o, m_err_o, m_int_o;
    logic [NS-1:0]   int_mask_i;
    logic [AW-1:0]   err_adr_o;
    logic [NS-1:0]   s_we_o, s_cyc_o, s_stb_o;
    logic [NS*4-1:0] s_sel_o;
    logic [NS*AW-1:0] s_adr_o;
    logic [NS*DW-1:0] s_dat_o;
    logic [NS*DW-1:0] s_dat_i;
    logic [NS-1:0]   s_ack_i, s_int_i;
    logic [1:0]      fsm_state;

    wishbone_interconnect_n #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .SEL_LSB(24), .SEL_WIDTH(8), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_int_o(m_int_o),
        .int_mask_i(int_mask_i), .err_adr_o(err_adr_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_int_i(s_int_i),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int passed;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (total=%0d passed=%0d)", total, passed);
        $fatal(1);
    end

    // ---------------- observations of one transfer ----------------
    logic [NS-1:0] obs_stb, obs_cyc, obs_we;
    logic [AW-1:0] obs_sadr;
    logic [DW-1:0] obs_sdat;
    logic [3:0]    obs_ssel;
    int            obs_ack_cnt, obs_lat, obs_stb_cycles;
    logic          obs_err, obs_stb_after, obs_multi;
    logic [DW-1:0] obs_dat;
    logic [AW-1:0] obs_erradr;

    // ---------------- reference model ----------------
    // Expected outcome from the interconnect's rules: address field picks the
    // slave, out-of-range -> decode error 1 cycle later, otherwise the slave
    // strobe is held until ack or T waiting cycles, then a single response.
    logic [NS-1:0] exp_stb, exp_we;
    logic          exp_err;
    logic [DW-1:0] exp_dat;
    logic [AW-1:0] exp_sadr;
    logic [AW-1:0] model_erradr;
    int            exp_lat, exp_stb_cycles;

    function automatic void model_txn(input logic [AW-1:0] adr, input bit we,
                                      input int delay, input logic [DW-1:0] rdat);
        int idx;
        int wait_cycles;
        idx = int'(adr[31:24]);
        exp_sadr = adr & 32'h00FF_FFFF;
        if (idx >= NS) begin
            exp_err = 1'b1;
            exp_lat = 1;
            exp_stb = '0;
            exp_stb_cycles = 0;
        end else begin
            wait_cycles = (delay == 0 || delay > T) ? T : delay;
            exp_err = (delay == 0 || delay > T);
            exp_lat = 1 + wait_cycles;
            exp_stb = NS'(1 << idx);
            exp_stb_cycles = wait_cycles;
        end
        exp_we  = we ? exp_stb : '0;
        exp_dat = (exp_err || we) ? '0 : rdat;
        if (exp_err) model_erradr = adr;
    endfunction

    // ---------------- driver: master + responding slave ----------------
    // delay = number of strobed cycles before the slave acks (0 = never);
    // hold = cycles the master keeps its strobe up after seeing the ack.
    task automatic run_txn(input logic [AW-1:0] adr, input bit we, input logic [DW-1:0] wdat,
                           input logic [3:0] sel, input int delay, input logic [DW-1:0] rdat,
                           input int hold);
        int idx;
        int after;
        bit acked;
        idx = int'(adr[31:24]);
        obs_stb = '0; obs_cyc = '0; obs_we = '0; obs_sadr = '0; obs_sdat = '0; obs_ssel = '0;
        obs_ack_cnt = 0; obs_lat = -1; obs_stb_cycles = 0; obs_err = 1'b0;
        obs_stb_after = 1'b0; obs_multi = 1'b0; obs_dat = '0; obs_erradr = '0;
        acked = 1'b0;
        after = 0;
        @(negedge clk);
        s_dat_i = {$urandom, $urandom, $urandom, $urandom};
        if (idx < NS) s_dat_i[idx*DW +: DW] = rdat;
        s_ack_i = '0;
        m_adr_i = adr; m_we_i = we; m_dat_i = wdat; m_sel_i = sel;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (s_stb_o != '0) begin
                if (acked) obs_stb_after = 1'b1;
                if ($countones(s_stb_o) != 1 || s_cyc_o != s_stb_o) obs_multi = 1'b1;
                if (obs_stb == '0 && idx < NS) begin
                    obs_stb  = s_stb_o;
                    obs_cyc  = s_cyc_o;
                    obs_we   = s_we_o;
                    obs_sadr = s_adr_o[idx*AW +: AW];
                    obs_sdat = s_dat_o[idx*DW +: DW];
                    obs_ssel = s_sel_o[idx*4 +: 4];
                end
            end
            if (idx < NS && s_stb_o[idx]) obs_stb_cycles++;
            if (m_ack_o) begin
                obs_ack_cnt++;
                if (!acked) begin
                    obs_err = m_err_o; obs_dat = m_dat_o; obs_erradr = err_adr_o; obs_lat = c;
                end
                acked = 1'b1;
            end
            s_ack_i = '0;
            if (idx < NS && s_stb_o[idx] && delay != 0 && obs_stb_cycles == delay) s_ack_i[idx] = 1'b1;
            if (acked) begin
                after++;
                if (after > hold) begin
                    m_stb_i = 1'b0;
                    m_cyc_i = 1'b0;
                end
                if (after > hold + 3) break;
            end
        end
        s_ack_i = '0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_erradr = '0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (m_ack_o !== 1'b0) $display("FAIL reset_ack: got %b want 0", m_ack_o); else passed++;
        total++; if (m_err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", m_err_o); else passed++;
        total++; if (m_int_o !== 1'b0) $display("FAIL reset_int: got %b want 0", m_int_o); else passed++;
        total++; if (m_dat_o !== '0) $display("FAIL reset_dat: got %h want 0", m_dat_o); else passed++;
        total++; if (err_adr_o !== '0) $display("FAIL reset_erradr: got %h want 0", err_adr_o); else passed++;
        total++; if ({s_stb_o, s_cyc_o, s_we_o} !== '0) $display("FAIL reset_strobes: got %b want 0", {s_stb_o, s_cyc_o, s_we_o}); else passed++;
        total++; if (s_adr_o !== '0 || s_dat_o !== '0 || s_sel_o !== '0) $display("FAIL reset_sbus: got adr %h dat %h sel %h want 0", s_adr_o, s_dat_o, s_sel_o); else passed++;
        total++; if (fsm_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE); else passed++;
    endtask

    task automatic test_read();
        model_txn(32'h0100_0010, 1'b0, 3, 32'hCAFE_BABE);
        run_txn(32'h0100_0010, 1'b0, 32'h0, 4'hF, 3, 32'hCAFE_BABE, 0);
        total++; if (obs_stb !== 4'b0010) $display("FAIL read_stb: got %b want 0010", obs_stb); else passed++;
        total++; if (obs_sadr !== 32'h0000_0010) $display("FAIL read_sadr: got %h want 00000010", obs_sadr); else passed++;
        total++; if (obs_ack_cnt !== 1) $display("FAIL read_ack_count: got %0d want 1", obs_ack_cnt); else passed++;
        total++; if (obs_dat !== 32'hCAFE_BABE) $display("FAIL read_data: got %h want cafebabe", obs_dat); else passed++;
        total++; if (obs_err !== 1'b0) $display("FAIL read_err: got %b want 0", obs_err); else passed++;
        total++; if (obs_lat !== exp_lat) $display("FAIL read_latency: got %0d want %0d", obs_lat, exp_lat); else passed++;
        total++; if (obs_we !== 4'b0000) $display("FAIL read_we: got %b want 0000", obs_we); else passed++;
    endtask

    task automatic test_write();
        model_txn(32'h0000_0004, 1'b1, 2, 32'h0);
        run_txn(32'h0000_0004, 1'b1, 32'h1234_5678, 4'hF, 2, 32'hDEAD_BEEF, 0);
        total++; if (obs_stb !== 4'b0001) $display("FAIL write_stb: got %b want 0001", obs_stb); else passed++;
        total++; if (obs_we !== 4'b0001) $display("FAIL write_we: got %b want 0001", obs_we); else passed++;
        total++; if (obs_sdat !== 32'h1234_5678) $display("FAIL write_sdat: got %h want 12345678", obs_sdat); else passed++;
        total++; if (obs_ssel !== 4'hF) $display("FAIL write_ssel: got %h want f", obs_ssel); else passed++;
        total++; if (obs_ack_cnt !== 1) $display("FAIL write_ack_count: got %0d want 1", obs_ack_cnt); else passed++;
        total++; if (obs_dat !== '0) $display("FAIL write_rdata: got %h want 0", obs_dat); else passed++;
    endtask

    task automatic test_decode_error();
        model_txn(32'h0500_0000, 1'b0, 1, 32'h0);
        run_txn(32'h0500_0000, 1'b0, 32'h0, 4'hF, 1, 32'h0, 0);
        total++; if (obs_ack_cnt !== 1 || obs_err !== 1'b1) $display("FAIL decode_ack_err: got ack %0d err %b want 1 1", obs_ack_cnt, obs_err); else passed++;
        total++; if (obs_lat !== 1) $display("FAIL decode_latency: got %0d want 1", obs_lat); else passed++;
        total++; if (obs_erradr !== 32'h0500_0000) $display("FAIL decode_erradr: got %h want 05000000", obs_erradr); else passed++;
        total++; if (obs_stb_after !== 1'b0 || obs_stb !== '0) $display("FAIL decode_no_stb: got seen %b want 0", obs_stb_after); else passed++;
    endtask

    task automatic test_timeout();
        model_txn(32'h0200_0000, 1'b0, 0, 32'h0);
        run_txn(32'h0200_0000, 1'b0, 32'h0, 4'h3, 0, 32'h5555_AAAA, 0);
        total++; if (obs_err !== 1'b1 || obs_ack_cnt !== 1) $display("FAIL timeout_err: got err %b ack %0d want 1 1", obs_err, obs_ack_cnt); else passed++;
        total++; if (obs_lat !== T + 1) $display("FAIL timeout_latency: got %0d want %0d", obs_lat, T + 1); else passed++;
        total++; if (obs_stb_cycles !== T) $display("FAIL timeout_busy_cycles: got %0d want %0d", obs_stb_cycles, T); else passed++;
        total++; if (obs_dat !== '0) $display("FAIL timeout_data: got %h want 0", obs_dat); else passed++;
        total++; if (obs_erradr !== 32'h0200_0000) $display("FAIL timeout_erradr: got %h want 02000000", obs_erradr); else passed++;
        total++; if (obs_stb_after !== 1'b0 || s_stb_o !== '0) $display("FAIL timeout_stb_cleared: got %b want 0", s_stb_o); else passed++;
        // Ack on the very last waiting cycle beats expiry.
        model_txn(32'h0300_0020, 1'b0, T, 32'h0BAD_F00D);
        run_txn(32'h0300_0020, 1'b0, 32'h0, 4'hF, T, 32'h0BAD_F00D, 0);
        total++; if (obs_err !== 1'b0 || obs_dat !== 32'h0BAD_F00D) $display("FAIL ack_at_expiry: got err %b dat %h want 0 0badf00d", obs_err, obs_dat); else passed++;
        total++; if (err_adr_o !== 32'h0200_0000) $display("FAIL ack_at_expiry_erradr: got %h want 02000000", err_adr_o); else passed++;
        model_txn(32'h0300_0024, 1'b0, T + 1, 32'h1111_2222);
        run_txn(32'h0300_0024, 1'b0, 32'h0, 4'hF, T + 1, 32'h1111_2222, 0);
        total++; if (obs_err !== 1'b1 || obs_lat !== T + 1) $display("FAIL ack_after_expiry: got err %b lat %0d want 1 %0d", obs_err, obs_lat, T + 1); else passed++;
    endtask

    task automatic test_back_to_back();
        // Held strobe must be answered only once.
        model_txn(32'h0100_0040, 1'b0, 1, 32'h7777_0001);
        run_txn(32'h0100_0040, 1'b0, 32'h0, 4'hF, 1, 32'h7777_0001, 4);
        total++; if (obs_ack_cnt !== 1) $display("FAIL held_stb_ack_count: got %0d want 1", obs_ack_cnt); else passed++;
        total++; if (obs_stb_after !== 1'b0) $display("FAIL held_stb_restrobe: got %b want 0", obs_stb_after); else passed++;
        total++; if (obs_lat !== exp_lat) $display("FAIL min_latency: got %0d want %0d", obs_lat, exp_lat); else passed++;
    endtask

    task automatic test_random();
        logic [AW-1:0] adr;
        logic [DW-1:0] wdat, rdat;
        logic [3:0] sel;
        bit we;
        int delay;
        for (int n = 0; n < 30; n++) begin
            adr   = {8'($urandom_range(0, 5)), 24'($urandom)};
            we    = 1'($urandom_range(0, 1));
            wdat  = $urandom;
            rdat  = $urandom;
            sel   = 4'($urandom);
            delay = $urandom_range(0, T + 3);
            model_txn(adr, we, delay, rdat);
            run_txn(adr, we, wdat, sel, delay, rdat, $urandom_range(0, 2));
            total++; if (obs_ack_cnt !== 1) $display("FAIL rnd%0d_ack_count: got %0d want 1", n, obs_ack_cnt); else passed++;
            total++; if (obs_err !== exp_err) $display("FAIL rnd%0d_err: got %b want %b", n, obs_err, exp_err); else passed++;
            total++; if (obs_dat !== exp_dat) $display("FAIL rnd%0d_data: got %h want %h", n, obs_dat, exp_dat); else passed++;
            total++; if (obs_lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d want %0d", n, obs_lat, exp_lat); else passed++;
            total++; if (obs_stb !== exp_stb || obs_cyc !== exp_stb || obs_we !== exp_we || obs_multi) $display("FAIL rnd%0d_strobes: got stb %b we %b want %b %b", n, obs_stb, obs_we, exp_stb, exp_we); else passed++;
            total++; if (exp_stb != '0 && (obs_sadr !== exp_sadr || obs_sdat !== wdat || obs_ssel !== sel)) $display("FAIL rnd%0d_sbus: got adr %h dat %h sel %h want %h %h %h", n, obs_sadr, obs_sdat, obs_ssel, exp_sadr, wdat, sel); else passed++;
            total++; if (err_adr_o !== model_erradr) $display("FAIL rnd%0d_erradr: got %h want %h", n, err_adr_o, model_erradr); else passed++;
        end
    endtask

    task automatic test_interrupts();
        logic [NS-1:0] iv, mv;
        @(negedge clk);
        s_int_i = 4'b0100; int_mask_i = 4'b1011;
        @(negedge clk);
        total++; if (m_int_o !== 1'b0) $display("FAIL int_masked: got %b want 0", m_int_o); else passed++;
        int_mask_i = 4'b1111;
        total++; if (m_int_o !== 1'b0) $display("FAIL int_not_yet: got %b want 0", m_int_o); else passed++;
        @(negedge clk);
        total++; if (m_int_o !== 1'b1) $display("FAIL int_unmasked: got %b want 1", m_int_o); else passed++;
        for (int n = 0; n < 10; n++) begin
            iv = NS'($urandom); mv = NS'($urandom);
            s_int_i = iv; int_mask_i = mv;
            @(negedge clk);
            total++; if (m_int_o !== |(iv & mv)) $display("FAIL int_rnd%0d: got %b want %b", n, m_int_o, |(iv & mv)); else passed++;
        end
        s_int_i = '0; int_mask_i = '0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int acks;
        @(negedge clk);
        m_adr_i = 32'h0200_0008; m_we_i = 1'b0; m_sel_i = 4'hF;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (s_stb_o !== 4'b0100) $display("FAIL abort_pre_stb: got %b want 0100", s_stb_o); else passed++;
        m_cyc_i = 1'b0;
        @(negedge clk);
        total++; if (s_stb_o !== '0 || s_cyc_o !== '0) $display("FAIL abort_stb: got %b want 0", s_stb_o); else passed++;
        total++; if (fsm_state !== ST_IDLE) $display("FAIL abort_state: got %0d want %0d", fsm_state, ST_IDLE); else passed++;
        acks = 0;
        for (int c = 0; c < T + 3; c++) begin
            @(negedge clk);
            if (m_ack_o) acks++;
        end
        total++; if (acks !== 0) $display("FAIL abort_no_ack: got %0d want 0", acks); else passed++;
        m_stb_i = 1'b0;
        // Reset asserted while the slave is being waited on.
        @(negedge clk);
        m_adr_i = 32'h0300_0000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (s_stb_o !== 4'b1000) $display("FAIL rst_busy_pre_stb: got %b want 1000", s_stb_o); else passed++;
        #1 rst = 1'b1;
        #1;
        total++; if (s_stb_o !== '0 || s_cyc_o !== '0 || m_ack_o !== 1'b0) $display("FAIL rst_busy_outputs: got stb %b ack %b want 0 0", s_stb_o, m_ack_o); else passed++;
        total++; if (fsm_state !== ST_IDLE) $display("FAIL rst_busy_state: got %0d want %0d", fsm_state, ST_IDLE); else passed++;
        total++; if (err_adr_o !== '0 || m_dat_o !== '0) $display("FAIL rst_busy_regs: got erradr %h dat %h want 0 0", err_adr_o, m_dat_o); else passed++;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_erradr = '0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (m_ack_o) acks++;
        end
        total++; if (acks !== 0) $display("FAIL rst_busy_no_ack: got %0d want 0", acks); else passed++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        total = 0; passed = 0;
        rst = 1'b1;
        m_we_i = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0; m_sel_i = '0;
        m_adr_i = '0; m_dat_i = '0; int_mask_i = '0;
        s_dat_i = '0; s_ack_i = '0; s_int_i = '0;
        model_erradr = '0;
        test_reset();
        test_read();
        test_write();
        test_decode_error();
        test_timeout();
        test_back_to_back();
        test_interrupts();
        test_random();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
